// File: rtl/rx78_pkg.sv
// Shared definitions for the RX-78 video memory subsystem.
//   - Default I/O port addresses of the plane-bank control registers.
//   - Fill engine state encoding.
//   - Status byte helper for the fill command/status register.
package rx78_pkg;

  localparam logic [7:0] FILL_PORT_DEF = 8'hF0;
  localparam logic [7:0] RD_PORT_DEF   = 8'hF1;
  localparam logic [7:0] WR_PORT_DEF   = 8'hF2;

  typedef enum logic {
    FILL_IDLE = 1'b0,
    FILL_RUN  = 1'b1
  } fill_state_e;

  // Status byte as seen by the CPU: bit 7 is the busy flag, the rest read 0.
  function automatic logic [7:0] fill_status(input logic busy_flag);
    return {busy_flag, 7'b0};
  endfunction

endpackage

// File: rtl/plane_ram.sv
// One bit-plane RAM: true dual-port, 2^AW words of DW bits.
//   clk    : clock
//   ce_n   : CPU/fill port enable (active low)
//   wr_n   : CPU/fill port write enable (active low, needs ce_n low)
//   addr   : CPU/fill port address
//   din    : CPU/fill port write data
//   q      : CPU/fill port registered read data (read-before-write)
//   vaddr  : video port address (read-only, always enabled)
//   vdata  : video port registered read data
module plane_ram #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          ce_n,
  input  logic          wr_n,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] q,
  input  logic [AW-1:0] vaddr,
  output logic [DW-1:0] vdata
);

  logic [DW-1:0] mem [2**AW];

  // The read register samples the old word, so a same-address write in
  // the same cycle is not visible on q until the next access.
  always_ff @(posedge clk) begin
    if (!ce_n) begin
      q <= mem[addr];
      if (!wr_n) begin
        mem[addr] <= din;
      end
    end
  end

  always_ff @(posedge clk) begin
    vdata <= mem[vaddr];
  end

endmodule

// File: rtl/vram_plane_bank.sv
// Bit-plane VRAM bank: PLANES plane RAMs behind one CPU memory window, with
// a read-plane select register, a write-plane mask register and a fill
// engine that clears/fills a masked set of planes while stalling the CPU.
//   clk, reset_n          : clock, synchronous active-low reset
//   io_wr/io_rd/io_addr   : I/O strobes and port address
//   io_din/io_dout        : I/O write data / registered I/O read data
//   mem_rd/mem_wr         : VRAM window strobes
//   mem_addr/mem_din      : VRAM window offset / write data
//   mem_dout              : CPU read data, valid the cycle after mem_rd
//   wait_n                : low while the fill engine blocks a CPU strobe
//   clear_req             : zero all planes
//   busy                  : fill engine active
//   vaddr/vdata           : VDP address / all plane words, plane i at [i*DW +: DW]
module vram_plane_bank
  import rx78_pkg::*;
#(
  parameter int         PLANES    = 6,
  parameter int         AW        = 13,
  parameter int         DW        = 8,
  parameter logic [7:0] RD_PORT   = RD_PORT_DEF,
  parameter logic [7:0] WR_PORT   = WR_PORT_DEF,
  parameter logic [7:0] FILL_PORT = FILL_PORT_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 io_wr,
  input  logic                 io_rd,
  input  logic [7:0]           io_addr,
  input  logic [7:0]           io_din,
  output logic [7:0]           io_dout,
  input  logic                 mem_rd,
  input  logic                 mem_wr,
  input  logic [AW-1:0]        mem_addr,
  input  logic [DW-1:0]        mem_din,
  output logic [DW-1:0]        mem_dout,
  output logic                 wait_n,
  input  logic                 clear_req,
  output logic                 busy,
  input  logic [AW-1:0]        vaddr,
  output logic [PLANES*DW-1:0] vdata
);

  // Control registers
  logic [7:0]        rd_sel_q, rd_sel_d;
  logic [7:0]        wr_mask_q, wr_mask_d;
  logic [7:0]        io_dout_q, io_dout_d;

  // Fill engine
  fill_state_e       state_q, state_d;
  logic [AW-1:0]     fill_addr_q, fill_addr_d;
  logic [PLANES-1:0] fill_mask_q, fill_mask_d;
  logic [DW-1:0]     fill_val_q, fill_val_d;

  // CPU read path
  logic              rd_pend_q, rd_pend_d;
  logic              rd_hit_q, rd_hit_d;
  logic [2:0]        rd_idx_q, rd_idx_d;
  logic [DW-1:0]     mem_hold_q;
  logic              vid_en_q;

  logic              fill_cmd;
  logic              cpu_rd, cpu_wr;
  logic              rd_hit;
  logic [2:0]        rd_idx;
  logic [AW-1:0]     port_addr;
  logic [DW-1:0]     port_din;
  logic [DW-1:0]     plane_q [PLANES];
  logic [DW-1:0]     plane_v [PLANES];
  logic [DW-1:0]     rd_word;

  assign fill_cmd = io_wr && (io_addr == FILL_PORT);

  // CPU strobes that arrive while the engine runs are dropped; the CPU
  // keeps holding them because wait_n is low.
  assign cpu_rd = mem_rd && !busy;
  assign cpu_wr = mem_wr && !busy;
  assign wait_n = !(busy && (mem_rd || mem_wr));

  assign rd_hit = (rd_sel_q != 8'd0) && (rd_sel_q <= 8'(PLANES));
  assign rd_idx = 3'(rd_sel_q - 8'd1);

  // The engine owns the shared port for its whole run.
  assign port_addr = busy ? fill_addr_q : mem_addr;
  assign port_din  = busy ? fill_val_q  : mem_din;

  // ---------------- register file / I/O read ----------------
  always_comb begin
    rd_sel_d  = rd_sel_q;
    wr_mask_d = wr_mask_q;
    io_dout_d = 8'hFF;
    if (io_wr && io_addr == RD_PORT) rd_sel_d  = io_din;
    if (io_wr && io_addr == WR_PORT) wr_mask_d = io_din;
    if (io_rd) begin
      if (io_addr == RD_PORT)        io_dout_d = rd_sel_q;
      else if (io_addr == WR_PORT)   io_dout_d = wr_mask_q;
      else if (io_addr == FILL_PORT) io_dout_d = fill_status(busy);
    end
  end

  // ---------------- fill FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= FILL_IDLE;
      fill_addr_q <= '0;
      fill_mask_q <= '0;
      fill_val_q  <= '0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      fill_mask_q <= fill_mask_d;
      fill_val_q  <= fill_val_d;
    end
  end

  // ---------------- fill FSM: next state ----------------
  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    fill_mask_d = fill_mask_q;
    fill_val_d  = fill_val_q;
    case (state_q)
      FILL_IDLE: begin
        fill_addr_d = '0;
        if (clear_req) begin
          state_d     = FILL_RUN;
          fill_mask_d = '1;
          fill_val_d  = '0;
        end else if (fill_cmd && (wr_mask_q[PLANES-1:0] != '0)) begin
          // The mask is captured here; later mask writes leave this run alone.
          state_d     = FILL_RUN;
          fill_mask_d = wr_mask_q[PLANES-1:0];
          fill_val_d  = DW'(io_din);
        end
      end
      FILL_RUN: begin
        if (&fill_addr_q) begin
          state_d = FILL_IDLE;
        end else begin
          fill_addr_d = fill_addr_q + 1'b1;
        end
      end
      default: state_d = FILL_IDLE;
    endcase
  end

  // ---------------- fill FSM: outputs ----------------
  always_comb begin
    busy = (state_q == FILL_RUN);
  end

  // ---------------- CPU read bookkeeping ----------------
  always_comb begin
    rd_pend_d = cpu_rd;
    rd_hit_d  = rd_hit;
    rd_idx_d  = rd_idx;
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < PLANES; i++) begin
      if (rd_idx_q == 3'(i)) rd_word = plane_q[i];
    end
  end

  // Right after a read the RAM register is presented directly; afterwards
  // the value is held, since the RAM register moves on fill/write traffic.
  always_comb begin
    mem_dout = mem_hold_q;
    if (rd_pend_q) begin
      mem_dout = rd_hit_q ? rd_word : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_sel_q   <= '0;
      wr_mask_q  <= '0;
      io_dout_q  <= 8'hFF;
      rd_pend_q  <= 1'b0;
      rd_hit_q   <= 1'b0;
      rd_idx_q   <= '0;
      mem_hold_q <= '0;
      vid_en_q   <= 1'b0;
    end else begin
      rd_sel_q   <= rd_sel_d;
      wr_mask_q  <= wr_mask_d;
      io_dout_q  <= io_dout_d;
      rd_pend_q  <= rd_pend_d;
      rd_hit_q   <= rd_hit_d;
      rd_idx_q   <= rd_idx_d;
      mem_hold_q <= mem_dout;
      vid_en_q   <= 1'b1;
    end
  end

  assign io_dout = io_dout_q;

  // ---------------- plane RAMs ----------------
  for (genvar gi = 0; gi < PLANES; gi++) begin : g_plane
    logic fill_we, cpu_we, cpu_re;
    logic ce_n, wr_n;

    assign fill_we = busy && fill_mask_q[gi];
    assign cpu_we  = cpu_wr && wr_mask_q[gi];
    assign cpu_re  = cpu_rd && rd_hit && (rd_idx == 3'(gi));
    // Nothing reaches the arrays while reset is held, so an aborted fill
    // leaves exactly the words written before the reset edge.
    assign ce_n    = !(reset_n && (fill_we || cpu_we || cpu_re));
    assign wr_n    = !(fill_we || cpu_we);

    plane_ram #(
      .AW(AW),
      .DW(DW)
    ) u_ram (
      .clk  (clk),
      .ce_n (ce_n),
      .wr_n (wr_n),
      .addr (port_addr),
      .din  (port_din),
      .q    (plane_q[gi]),
      .vaddr(vaddr),
      .vdata(plane_v[gi])
    );

    // Video output reads as zero until the first post-reset edge.
    assign vdata[gi*DW +: DW] = vid_en_q ? plane_v[gi] : '0;
  end

endmodule

// File: doc/vram_plane_bank.md
# vram_plane_bank

Parametrised bit-plane VRAM subsystem for the video side of the core: `PLANES` independent plane RAMs behind a single CPU memory window, with a read-plane select register, a write-plane mask, and a second per-plane port for the VDP. It replaces fixed six-plane wiring and the combinational "zero VRAM during cart upload" hack with a hardware fill engine. That engine clears or fills any masked set of planes and stalls the CPU while it runs. It sits between the Z80 bus decode and the `vdp`.

## Interface

Parameters:
- `PLANES`, 6: number of bit-plane RAMs (1..8).
- `AW`, 13: plane address width. Each plane holds 2^AW words.
- `DW`, 8: data width.
- `RD_PORT`, 8'hF1: I/O address of the read-plane select register.
- `WR_PORT`, 8'hF2: I/O address of the write-plane mask register.
- `FILL_PORT`, 8'hF0: I/O address of the fill command and status register.

Ports:
- `clk` in 1: system clock, sole clock. Rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `io_wr` in 1: single-cycle I/O write strobe.
- `io_rd` in 1: single-cycle I/O read strobe.
- `io_addr` in 8: I/O port address.
- `io_din` in 8: I/O write data.
- `io_dout` out 8: registered I/O read data.
- `mem_rd` in 1: single-cycle VRAM-window read strobe.
- `mem_wr` in 1: single-cycle VRAM-window write strobe.
- `mem_addr` in AW: VRAM-window offset.
- `mem_din` in DW: CPU write data.
- `mem_dout` out DW: registered CPU read data.
- `wait_n` out 1: low while the fill engine owns the planes and a CPU memory strobe is present.
- `clear_req` in 1: pulse that zeroes all planes (cart-upload start).
- `busy` out 1: fill engine active.
- `vaddr` in AW: VDP address.
- `vdata` out PLANES*DW: all plane words. Plane i occupies bits [i*DW +: DW].

## Operation

Registers (all reset values apply when `reset_n`=0 at an edge):
- `rd_sel`: 8 bits, reset 0. Value k in 1..PLANES selects plane k-1 for CPU reads. Any other value makes CPU reads return 0.
- `wr_mask`: 8 bits, reset 0. Bit i set means CPU writes go to plane i. Bits at i ≥ PLANES are ignored. Mask 0 means writes are dropped.
- `io_dout`:
  - reset 8'hFF.
  - Each cycle defaults to 8'hFF.
  - `io_rd` at `RD_PORT` returns `rd_sel`. At `WR_PORT` it returns `wr_mask`. At `FILL_PORT` it returns {`busy`, 7'b0}.
- `mem_dout`: reset 0. On `mem_rd` it loads the selected plane word, or 0 when no plane is selected.
- `busy`: reset 0. `wait_n`: reset 1. `vdata`: reset 0, thereafter the registered RAM output.

Fill engine FSM:
- States: IDLE, FILL.
- IDLE→FILL on `clear_req`:
  - target = all planes; value = 0.
- IDLE→FILL on `io_wr` at `FILL_PORT`:
  - target = `wr_mask` snapshot taken at command time; value = `io_din`.
  - If the snapshotted mask is 0, the FSM stays in IDLE.
- FILL:
  - Address counter starts at 0 and writes one word per cycle to every target plane.
  - At address 2^AW−1 it writes and returns to IDLE. The counter does not wrap further.
- `clear_req` and fill command in the same cycle: clear wins.
- Fill commands or `clear_req` while in FILL are ignored.
- Register writes during FILL:
  - `rd_sel` and `wr_mask` writes are accepted.
  - They do not alter an in-progress fill, which uses its snapshot.

CPU access during FILL:
- `wait_n` is driven low combinationally whenever `busy` is set and `mem_rd` or `mem_wr` is present.
- Strobes while `busy` is set are discarded. The CPU must hold them (Z80 wait semantics).
- `io_*` accesses are never stalled.

VDP port:
- Independent second port on each plane, always active.
- Fill writes are visible on `vdata` like any other write.

Reset mid-fill: FSM returns to IDLE, all registers take their reset values, and partially filled plane contents are left as they are.

## Timing

- I/O read latency: `io_dout` is valid on the cycle after `io_rd`. Register writes take effect on the following edge.
- CPU memory read: `mem_dout` is valid 1 cycle after `mem_rd`. It reads the pre-write value if the same address is written in that cycle.
- CPU memory write: lands on the edge at which `mem_wr` is sampled.
- VDP: `vdata` is valid 1 cycle after `vaddr`.
- Fill:
  - Command sampled at edge N.
  - `busy`=1 from N+1 to N+2^AW inclusive, i.e. exactly 2^AW busy cycles.
  - First word written at N+1. `busy`=0 at N+2^AW+1.

## Structure

- Shared package `rx78_pkg`: port address constants and the fill FSM state enum.
- Sub-module `plane_ram`: true dual-port RAM, parameters AW and DW. One CPU/fill port (`ce_n`, `wr_n`, `addr`, `din`, `q`) and one read-only video port (`vaddr`, `vdata`). Instantiated PLANES times with a generate loop.

## Test plan

- Reset:
  - Stimulus: assert `reset_n`=0 for 2 cycles.
  - Expect `io_dout`=8'hFF, `busy`=0, `wait_n`=1, `mem_dout`=0.
  - Read `RD_PORT` and `WR_PORT` → 8'h00.
- Masked write and plane read:
  - Stimulus: `wr_mask`=8'h05, write 8'hA5 at address 0x0123, set `rd_sel`=1 and read.
  - Expect 8'hA5 with `rd_sel`=1.
  - `rd_sel`=2 → 8'h00. `rd_sel`=3 → 8'hA5. `rd_sel`=7 → 8'h00.
  - Corresponding `vdata` planes 0 and 2 = 8'hA5 one cycle after `vaddr`=0x0123.
- Fill:
  - Stimulus: `wr_mask`=8'h02, write 8'h3C to `FILL_PORT`.
  - Expect `busy` high for exactly 8192 cycles; plane 1 addresses 0, 0x1000, 0x1FFF = 8'h3C; plane 0 unchanged.
- Stall:
  - Stimulus: `mem_rd` mid-fill, held until `wait_n` rises.
  - Expect `wait_n`=0 until the cycle after `busy` falls; then correct data 1 cycle later.
  - Read of `FILL_PORT` mid-fill → 8'h80.
- Priority and reset:
  - Stimulus: `clear_req` and fill command in the same cycle.
  - Expect all planes zeroed.
  - Stimulus: `reset_n`=0 at fill cycle 100.
  - Expect `busy`=0 next cycle and addresses ≥100 unchanged.
